// File: rtl/scan_ctrl.sv
// Scan chain sequencer: shifts a pattern in, pulses one capture, shifts the response out.
// Latency: done pulses 2*CHAIN_LEN+2 cycles after start is sampled; every output is registered.
// No backpressure: start is taken only in IDLE and dropped while busy; abort returns to IDLE on the next edge.
// Optional build macro SCAN_CTRL_COMPARE_EN adds the expected input and the sticky fail output.
module scan_ctrl #(
    parameter int CHAIN_LEN = 16
) (
    input  logic                 C,
    input  logic                 R,
    input  logic                 start,
    input  logic                 abort,
    input  logic [CHAIN_LEN-1:0] pattern,
    input  logic                 scan_out,
    output logic                 scan_en,
    output logic                 scan_in,
    output logic                 cap_en,
    output logic                 busy,
    output logic                 done,
    output logic [CHAIN_LEN-1:0] result
`ifdef SCAN_CTRL_COMPARE_EN
    ,
    input  logic [CHAIN_LEN-1:0] expected,
    output logic                 fail
`endif
);

    // Counter only has to reach CHAIN_LEN-1; sized for CHAIN_LEN so it can never wrap.
    localparam int CW = $clog2(CHAIN_LEN + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CHAIN_LEN - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SHIFT_IN  = 3'd1,
        CAPTURE   = 3'd2,
        SHIFT_OUT = 3'd3,
        DONE      = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [CHAIN_LEN-1:0]   sreg_q, sreg_d;
    logic [CHAIN_LEN-1:0]   result_q, result_d;
    logic                   scan_en_q, scan_en_d;
    logic                   scan_in_q, scan_in_d;
    logic                   cap_en_q, cap_en_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
`ifdef SCAN_CTRL_COMPARE_EN
    logic                   fail_q, fail_d;
`endif

    // Next state plus the output values that go with it, so outputs come straight from flops.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sreg_d    = sreg_q;
        result_d  = result_q;
        scan_en_d = 1'b0;
        scan_in_d = 1'b0;
        cap_en_d  = 1'b0;
        busy_d    = 1'b0;
        done_d    = 1'b0;
`ifdef SCAN_CTRL_COMPARE_EN
        fail_d    = fail_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    // Bit 0 goes out in the first SHIFT_IN cycle, the rest wait in sreg.
                    state_d   = SHIFT_IN;
                    cnt_d     = '0;
                    sreg_d    = pattern >> 1;
                    scan_in_d = pattern[0];
                    scan_en_d = 1'b1;
                    busy_d    = 1'b1;
                end
            end
            SHIFT_IN: begin
                busy_d = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d  = CAPTURE;
                    cnt_d    = '0;
                    cap_en_d = 1'b1;
                end else begin
                    cnt_d     = cnt_q + CW'(1);
                    scan_en_d = 1'b1;
                    scan_in_d = sreg_q[0];
                    sreg_d    = sreg_q >> 1;
                end
            end
            CAPTURE: begin
                state_d   = SHIFT_OUT;
                cnt_d     = '0;
                scan_en_d = 1'b1;
                busy_d    = 1'b1;
            end
            SHIFT_OUT: begin
                busy_d   = 1'b1;
                // Shift in from the top: after CHAIN_LEN samples the first one sits in bit 0.
                result_d = {scan_out, result_q[CHAIN_LEN-1:1]};
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
`ifdef SCAN_CTRL_COMPARE_EN
                    fail_d  = (result_d != expected);
`endif
                end else begin
                    cnt_d     = cnt_q + CW'(1);
                    scan_en_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort wins over everything in a busy state; result keeps whatever it has so far.
        if (abort && (state_q != IDLE)) begin
            state_d   = IDLE;
            cnt_d     = '0;
            sreg_d    = sreg_q;
            result_d  = result_q;
            scan_en_d = 1'b0;
            scan_in_d = 1'b0;
            cap_en_d  = 1'b0;
            busy_d    = 1'b0;
            done_d    = 1'b0;
`ifdef SCAN_CTRL_COMPARE_EN
            fail_d    = fail_q;
`endif
        end
    end

    // State and output registers, cleared asynchronously by R.
    always_ff @(posedge C or posedge R) begin
        if (R) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            sreg_q    <= '0;
            result_q  <= '0;
            scan_en_q <= 1'b0;
            scan_in_q <= 1'b0;
            cap_en_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef SCAN_CTRL_COMPARE_EN
            fail_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sreg_q    <= sreg_d;
            result_q  <= result_d;
            scan_en_q <= scan_en_d;
            scan_in_q <= scan_in_d;
            cap_en_q  <= cap_en_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef SCAN_CTRL_COMPARE_EN
            fail_q    <= fail_d;
`endif
        end
    end

    assign scan_en = scan_en_q;
    assign scan_in = scan_in_q;
    assign cap_en  = cap_en_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign result  = result_q;
`ifdef SCAN_CTRL_COMPARE_EN
    assign fail    = fail_q;
`endif

endmodule

// File: tb/tb_scan_ctrl.sv
// Bench for scan_ctrl with CHAIN_LEN=16: directed scenarios plus randomized sequences.
// Expected outputs come from the cycle timeline (start sampled at cycle 0).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_scan_ctrl;

    localparam int N = 16;

    logic         C = 1'b0;
    logic         R = 1'b0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [N-1:0] pattern = '0;
    logic         scan_out = 1'b0;
    logic         scan_en, scan_in, cap_en, busy, done;
    logic [N-1:0] result;
`ifdef SCAN_CTRL_COMPARE_EN
    logic [N-1:0] expected = '0;
    logic         fail;
    logic         fail_model = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state for the result register.
    logic [N-1:0] res_model = '0;
    bit           res_known = 1'b1;

    scan_ctrl #(.CHAIN_LEN(N)) dut (
        .C        (C),
        .R        (R),
        .start    (start),
        .abort    (abort),
        .pattern  (pattern),
        .scan_out (scan_out),
        .scan_en  (scan_en),
        .scan_in  (scan_in),
        .cap_en   (cap_en),
        .busy     (busy),
        .done     (done),
        .result   (result)
`ifdef SCAN_CTRL_COMPARE_EN
        ,
        .expected (expected),
        .fail     (fail)
`endif
    );

    always #5 C = ~C;

    function automatic logic [N-1:0] rnd_vec();
        logic [31:0] t;
        t = $urandom();
        return t[N-1:0];
    endfunction

    // One sequence from cycle 0 (start driven) to cycle 2N+3 (back in IDLE).
    // abort_at < 0: no abort. st_a/st_b: extra start pulses while busy (<0: none).
    task automatic run_seq(input logic [N-1:0] pat, input logic [N-1:0] so,
                           input int abort_at, input int st_a, input int st_b,
                           input bit abort_idle, input string name);
        int       last;
        bit       alive;
        logic [4:0] got, want;
        logic [N-1:0] junk;
        logic [31:0]  r;
        last = 2*N + 3;
        for (int c = 0; c <= last; c++) begin
            @(negedge C);
            alive = (c >= 1) && (c <= 2*N + 2) && (abort_at < 0 || c <= abort_at);
            want = '0;
            if (alive) begin
                want[4] = 1'b1;
                want[3] = (c <= N) || (c >= N + 2 && c <= 2*N + 1);
                want[2] = (c <= N) ? pat[c-1] : 1'b0;
                want[1] = (c == N + 1);
                want[0] = (c == 2*N + 2);
            end
            got = {busy, scan_en, scan_in, cap_en, done};
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL %s ctrl c=%0d {busy,scan_en,scan_in,cap_en,done} got %b want %b",
                         name, c, got, want);
            end
            // Result holds its old value until shift-out samples land, and equals the stream at done.
            if (abort_at < 0 && c >= 2*N + 2) begin
                n_checks++;
                if (result !== so) begin
                    n_fail++;
                    $display("FAIL %s result c=%0d got %h want %h", name, c, result, so);
                end
            end else if (res_known && (c <= N + 2 || (abort_at >= 0 && abort_at < N + 2))) begin
                n_checks++;
                if (result !== res_model) begin
                    n_fail++;
                    $display("FAIL %s result_hold c=%0d got %h want %h", name, c, result, res_model);
                end
            end
`ifdef SCAN_CTRL_COMPARE_EN
            n_checks++;
            if (fail !== ((abort_at < 0 && c >= 2*N + 2) ? (so != expected) : fail_model)) begin
                n_fail++;
                $display("FAIL %s fail c=%0d got %b want %b", name, c, fail,
                         (abort_at < 0 && c >= 2*N + 2) ? (so != expected) : fail_model);
            end
`endif
            // Drive inputs for cycle c.
            junk     = rnd_vec();
            r        = $urandom();
            pattern  = (c == 0) ? pat : junk;
            start    = (c == 0) || (c == st_a) || (c == st_b);
            abort    = (c == abort_at) || (abort_idle && (c == 0 || c == last));
            scan_out = (c >= N + 2 && c <= 2*N + 1) ? so[c-N-2] : r[0];
        end
        start = 1'b0;
        if (abort_at < 0) begin
            res_model = so;
            res_known = 1'b1;
`ifdef SCAN_CTRL_COMPARE_EN
            fail_model = (so != expected);
`endif
        end else if (abort_at >= N + 2) begin
            res_known = 1'b0;
        end
    endtask

    task automatic test_reset();
        R = 1'b0;
        #1 R = 1'b1;
        #1;
        n_checks++;
        if ({busy, scan_en, scan_in, cap_en, done, result} !== '0) begin
            n_fail++;
            $display("FAIL reset_async outputs got %b/%h want all zero",
                     {busy, scan_en, scan_in, cap_en, done}, result);
        end
        repeat (2) @(negedge C);
        R = 1'b0;
        @(negedge C);
        n_checks++;
        if ({busy, scan_en, scan_in, cap_en, done, result} !== '0) begin
            n_fail++;
            $display("FAIL reset_idle outputs got %b/%h want all zero",
                     {busy, scan_en, scan_in, cap_en, done}, result);
        end
`ifdef SCAN_CTRL_COMPARE_EN
        n_checks++;
        if (fail !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_fail got %b want 0", fail);
        end
`endif
        res_model = '0;
        res_known = 1'b1;
    endtask

    task automatic test_basic();
        run_seq(16'h0001, rnd_vec(), -1, -1, -1, 1'b0, "basic_p0001");
    endtask

    task automatic test_result();
        run_seq(rnd_vec(), 16'hFFFF, -1, -1, -1, 1'b0, "result_ffff");
        run_seq(rnd_vec(), 16'h0004, -1, -1, -1, 1'b0, "result_0004");
    endtask

    task automatic test_abort();
        run_seq(rnd_vec(), rnd_vec(), 5, -1, -1, 1'b0, "abort_c5");
        run_seq(rnd_vec(), rnd_vec(), -1, -1, -1, 1'b0, "after_abort");
    endtask

    task automatic test_back_to_back();
        run_seq(rnd_vec(), rnd_vec(), -1, 3, 20, 1'b0, "ignore_start");
    endtask

    task automatic test_reset_mid();
        logic [31:0] r;
        @(negedge C);
        pattern = rnd_vec();
        start   = 1'b1;
        for (int c = 1; c <= N + 5; c++) begin
            @(negedge C);
            r        = $urandom();
            start    = 1'b0;
            scan_out = r[0];
        end
        #2 R = 1'b1;
        #1;
        n_checks++;
        if ({busy, scan_en, scan_in, cap_en, done, result} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid outputs got %b/%h want all zero",
                     {busy, scan_en, scan_in, cap_en, done}, result);
        end
        @(negedge C);
        R = 1'b0;
        res_model = '0;
        res_known = 1'b1;
`ifdef SCAN_CTRL_COMPARE_EN
        fail_model = 1'b0;
`endif
        run_seq(rnd_vec(), rnd_vec(), -1, -1, -1, 1'b0, "after_reset");
    endtask

    task automatic test_random();
        int ab, sa, sb, lim;
        for (int i = 0; i < 14; i++) begin
            ab  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 2*N + 2)) : -1;
            lim = (ab > 0) ? ab : 2*N + 2;
            sa  = int'($urandom_range(1, lim));
            sb  = int'($urandom_range(1, lim));
`ifdef SCAN_CTRL_COMPARE_EN
            expected = rnd_vec();
`endif
            run_seq(rnd_vec(), rnd_vec(), ab, sa, sb, bit'($urandom_range(0, 1)), "random");
        end
    endtask

`ifdef SCAN_CTRL_COMPARE_EN
    task automatic test_compare();
        expected = 16'hFFFF;
        run_seq(rnd_vec(), 16'hFFFF, -1, -1, -1, 1'b0, "compare_match");
        expected = 16'hFFFE;
        run_seq(rnd_vec(), 16'hFFFF, -1, -1, -1, 1'b0, "compare_miss");
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_result();
        test_abort();
        test_back_to_back();
        test_reset_mid();
`ifdef SCAN_CTRL_COMPARE_EN
        test_compare();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
